// File: rtl/const_seq_gen_pkg.sv
// rtl/const_seq_gen_pkg.sv - shared encodings and helpers for const_seq_gen
package const_seq_gen_pkg;

    localparam logic [1:0] MODE_ZERO  = 2'd0;
    localparam logic [1:0] MODE_CONST = 2'd1;
    localparam logic [1:0] MODE_RAMP  = 2'd2;

    localparam logic [1:0] FLD_MODE  = 2'd0;
    localparam logic [1:0] FLD_START = 2'd1;
    localparam logic [1:0] FLD_STEP  = 2'd2;
    localparam logic [1:0] FLD_LIMIT = 2'd3;

    // Decoded per-channel control; the reserved mode decodes like ZERO.
    typedef struct packed {
        logic load_start;
        logic ramp;
    } ch_ctl_t;

    function automatic ch_ctl_t decode_mode(input logic [1:0] mode);
        ch_ctl_t ctl;
        ctl.load_start = (mode == MODE_CONST) || (mode == MODE_RAMP);
        ctl.ramp       = (mode == MODE_RAMP);
        return ctl;
    endfunction

endpackage

// File: rtl/const_seq_gen_ch.sv
// rtl/const_seq_gen_ch.sv - one channel: config shadow, active config, out/wrap registers (CONST_SEQ_GEN_LIMIT_EN)
module const_seq_gen_ch
    import const_seq_gen_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             init,
    input  logic             advance,
    input  logic             we,
    input  logic [1:0]       field,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] out,
    output logic             wrap
);

    logic [1:0]       cfg_mode;
    logic [WIDTH-1:0] cfg_start;
    logic [WIDTH-1:0] cfg_step;
    logic             act_ramp;
    logic [WIDTH-1:0] act_step;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] nxt_out;
    logic             nxt_wrap;
    ch_ctl_t          cfg_ctl;

`ifdef CONST_SEQ_GEN_LIMIT_EN
    logic [WIDTH-1:0] cfg_limit;
    logic [WIDTH-1:0] act_limit;
    logic [WIDTH-1:0] act_start;
`endif

    assign cfg_ctl = decode_mode(cfg_mode);
    assign sum     = {1'b0, out} + {1'b0, act_step};

    always_comb begin
        nxt_out  = out;
        nxt_wrap = 1'b0;
        if (init) begin
            nxt_out = cfg_ctl.load_start ? cfg_start : '0;
        end else if (advance && act_ramp) begin
`ifdef CONST_SEQ_GEN_LIMIT_EN
            if (sum > {1'b0, act_limit}) begin
                nxt_out  = act_start;
                nxt_wrap = 1'b1;
            end else begin
                nxt_out  = sum[WIDTH-1:0];
            end
`else
            nxt_out  = sum[WIDTH-1:0];
            nxt_wrap = sum[WIDTH];
`endif
        end
    end

    // Writes land in the shadow set; only init copies them into the active set.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cfg_mode  <= MODE_ZERO;
            cfg_start <= '0;
            cfg_step  <= '0;
            act_ramp  <= 1'b0;
            act_step  <= '0;
            out       <= '0;
            wrap      <= 1'b0;
`ifdef CONST_SEQ_GEN_LIMIT_EN
            cfg_limit <= '0;
            act_limit <= '0;
            act_start <= '0;
`endif
        end else begin
            if (init) begin
                act_ramp  <= cfg_ctl.ramp;
                act_step  <= cfg_step;
`ifdef CONST_SEQ_GEN_LIMIT_EN
                act_limit <= cfg_limit;
                act_start <= cfg_start;
`endif
            end
            if (we) begin
                case (field)
                    FLD_MODE:  cfg_mode  <= wdata[1:0];
                    FLD_START: cfg_start <= wdata;
                    FLD_STEP:  cfg_step  <= wdata;
`ifdef CONST_SEQ_GEN_LIMIT_EN
                    FLD_LIMIT: cfg_limit <= wdata;
`endif
                    default: ;
                endcase
            end
            out  <= nxt_out;
            wrap <= nxt_wrap;
        end
    end

endmodule

// File: rtl/const_seq_gen.sv
// rtl/const_seq_gen.sv - multi-channel constant/ramp source top (CONST_SEQ_GEN_LIMIT_EN)
module const_seq_gen
    import const_seq_gen_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NCH    = 4,
    parameter int ADDR_W = $clog2(NCH) + 2
) (
    input  logic                 const_seq_gen_clk,
    input  logic                 const_seq_gen_reset,
    input  logic                 const_seq_gen_init,
    input  logic                 const_seq_gen_in_disable,
    input  logic                 const_seq_gen_cfg_we,
    input  logic [ADDR_W-1:0]    const_seq_gen_cfg_addr,
    input  logic [WIDTH-1:0]     const_seq_gen_cfg_wdata,
    output logic [NCH*WIDTH-1:0] const_seq_gen_out,
    output logic                 const_seq_gen_out_valid,
    output logic [NCH-1:0]       const_seq_gen_wrap
);

    localparam int CW = (ADDR_W > 2) ? ADDR_W - 2 : 1;

    logic [CW-1:0] ch_idx;
    logic          advance;

    generate
        if (ADDR_W > 2) begin : g_idx
            assign ch_idx = const_seq_gen_cfg_addr[ADDR_W-1:2];
        end else begin : g_idx1
            assign ch_idx = '0;
        end
    endgenerate

    assign advance = const_seq_gen_out_valid && !const_seq_gen_init && !const_seq_gen_in_disable;

    always_ff @(posedge const_seq_gen_clk) begin
        if (!const_seq_gen_reset) begin
            const_seq_gen_out_valid <= 1'b0;
        end else if (const_seq_gen_init) begin
            const_seq_gen_out_valid <= 1'b1;
        end
    end

    // Indices at or above NCH match no channel, so those writes vanish.
    generate
        for (genvar c = 0; c < NCH; c++) begin : g_ch
            logic we_c;
            assign we_c = const_seq_gen_cfg_we && (ch_idx == CW'(c));

            const_seq_gen_ch #(.WIDTH(WIDTH)) u_ch (
                .clk     (const_seq_gen_clk),
                .resetn  (const_seq_gen_reset),
                .init    (const_seq_gen_init),
                .advance (advance),
                .we      (we_c),
                .field   (const_seq_gen_cfg_addr[1:0]),
                .wdata   (const_seq_gen_cfg_wdata),
                .out     (const_seq_gen_out[c*WIDTH +: WIDTH]),
                .wrap    (const_seq_gen_wrap[c])
            );
        end
    endgenerate

endmodule

// File: tb/tb_const_seq_gen.sv
// tb/tb_const_seq_gen.sv - scoreboard bench for const_seq_gen
module tb_const_seq_gen;

    localparam int W = 32;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst, init, dis, we;
    logic [3:0]     addr;
    logic [W-1:0]   wdata;
    logic [N*W-1:0] dout;
    logic           valid;
    logic [N-1:0]   wrap;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [N*W-1:0] out;
        logic           valid;
        logic [N-1:0]   wrap;
    } exp_t;

    exp_t sb[$];

    logic [1:0]   m_mode[N];
    logic [W-1:0] m_start[N], m_step[N], m_limit[N];
    logic         a_ramp[N];
    logic [W-1:0] a_step[N], a_start[N], a_limit[N];
    logic [W-1:0] m_out[N];
    logic         m_wrap[N];
    logic         m_valid;

    always #5 clk = ~clk;

    const_seq_gen #(.WIDTH(W), .NCH(N)) dut (
        .const_seq_gen_clk        (clk),
        .const_seq_gen_reset      (rst),
        .const_seq_gen_init       (init),
        .const_seq_gen_in_disable (dis),
        .const_seq_gen_cfg_we     (we),
        .const_seq_gen_cfg_addr   (addr),
        .const_seq_gen_cfg_wdata  (wdata),
        .const_seq_gen_out        (dout),
        .const_seq_gen_out_valid  (valid),
        .const_seq_gen_wrap       (wrap)
    );

    task automatic check(input string tag, input logic [N*W-1:0] got, input logic [N*W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ch(input int c);
        return dout[c*W +: W];
    endfunction

    function automatic logic [3:0] ad(input int c, input int f);
        return 4'(c * 4 + f);
    endfunction

    task automatic model_step();
        logic [W:0] s;
        if (!rst) begin
            for (int c = 0; c < N; c++) begin
                m_mode[c] = 0; m_start[c] = 0; m_step[c] = 0; m_limit[c] = 0;
                a_ramp[c] = 0; a_step[c] = 0; a_start[c] = 0; a_limit[c] = 0;
                m_out[c] = 0; m_wrap[c] = 0;
            end
            m_valid = 0;
        end else begin
            for (int c = 0; c < N; c++) begin
                if (init) begin
                    a_ramp[c]  = (m_mode[c] == 2'd2);
                    a_step[c]  = m_step[c];
                    a_start[c] = m_start[c];
                    a_limit[c] = m_limit[c];
                    m_out[c]   = (m_mode[c] == 2'd1 || m_mode[c] == 2'd2) ? m_start[c] : '0;
                    m_wrap[c]  = 0;
                end else if (m_valid && !dis && a_ramp[c]) begin
                    s = {1'b0, m_out[c]} + {1'b0, a_step[c]};
`ifdef CONST_SEQ_GEN_LIMIT_EN
                    if (s > {1'b0, a_limit[c]}) begin
                        m_out[c] = a_start[c]; m_wrap[c] = 1;
                    end else begin
                        m_out[c] = s[W-1:0]; m_wrap[c] = 0;
                    end
`else
                    m_out[c]  = s[W-1:0];
                    m_wrap[c] = s[W];
`endif
                end else begin
                    m_wrap[c] = 0;
                end
            end
            if (we) begin
                case (addr[1:0])
                    2'd0: m_mode[addr[3:2]]  = wdata[1:0];
                    2'd1: m_start[addr[3:2]] = wdata;
                    2'd2: m_step[addr[3:2]]  = wdata;
`ifdef CONST_SEQ_GEN_LIMIT_EN
                    2'd3: m_limit[addr[3:2]] = wdata;
`endif
                    default: ;
                endcase
            end
            if (init) m_valid = 1;
        end
    endtask

    task automatic cyc(input logic r, input logic i, input logic d, input logic w,
                       input logic [3:0] a, input logic [W-1:0] wd);
        exp_t e;
        rst = r; init = i; dis = d; we = w; addr = a; wdata = wd;
        model_step();
        for (int c = 0; c < N; c++) begin
            e.out[c*W +: W] = m_out[c];
            e.wrap[c]       = m_wrap[c];
        end
        e.valid = m_valid;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("sb_out", dout, e.out);
        check("sb_valid", {{(N*W-1){1'b0}}, valid}, {{(N*W-1){1'b0}}, e.valid});
        check("sb_wrap", {{(N*W-N){1'b0}}, wrap}, {{(N*W-N){1'b0}}, e.wrap});
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc(1, 0, 0, 0, 4'd0, '0);
    endtask

    task automatic wr(input int c, input int f, input logic [W-1:0] v);
        cyc(1, 0, 0, 1, ad(c, f), v);
    endtask

    initial begin
        logic [W-1:0] v;
        rst = 0; init = 0; dis = 0; we = 0; addr = 0; wdata = 0;
        cyc(0, 0, 0, 0, 4'd0, '0);
        cyc(0, 0, 0, 0, 4'd0, '0);
        check("rst_out", dout, '0);
        check("rst_valid", N*W'(valid), '0);

        wr(0, 0, 32'd1); wr(0, 1, 32'hDEADBEEF);
        wr(1, 0, 32'd0); wr(1, 1, 32'd5);
        wr(2, 0, 32'd2); wr(2, 1, 32'hFFFFFFFD); wr(2, 2, 32'd1); wr(2, 3, 32'hFFFFFFFF);
        wr(3, 0, 32'd2); wr(3, 1, 32'd0); wr(3, 2, 32'd4); wr(3, 3, 32'hFFFFFFFF);
        check("pre_init_out", dout, '0);

        cyc(1, 1, 0, 0, 4'd0, '0);
        check("init_ch0", N*W'(ch(0)), N*W'(32'hDEADBEEF));
        check("init_ch1", N*W'(ch(1)), '0);
        check("init_ch2", N*W'(ch(2)), N*W'(32'hFFFFFFFD));
        check("init_valid", N*W'(valid), N*W'(1));

        run(1);
        check("ramp_ch2_1", N*W'(ch(2)), N*W'(32'hFFFFFFFE));
        run(1);
        check("ramp_ch2_2", N*W'(ch(2)), N*W'(32'hFFFFFFFF));
        check("ramp_ch3_2", N*W'(ch(3)), N*W'(32'd8));
        for (int k = 0; k < 3; k++) cyc(1, 0, 1, 0, 4'd0, '0);
        check("dis_hold_ch3", N*W'(ch(3)), N*W'(32'd8));
        check("dis_wrap", N*W'(wrap), '0);
        run(1);
        check("after_dis_ch3", N*W'(ch(3)), N*W'(32'd12));
`ifdef CONST_SEQ_GEN_LIMIT_EN
        check("wrap_ch2_val", N*W'(ch(2)), N*W'(32'hFFFFFFFD));
`else
        check("wrap_ch2_val", N*W'(ch(2)), '0);
`endif
        check("wrap_ch2_flag", N*W'(wrap), N*W'(4'b0100));
        run(10);
        check("hold_ch0", N*W'(ch(0)), N*W'(32'hDEADBEEF));
        check("hold_ch1", N*W'(ch(1)), '0);

        v = ch(3);
        wr(3, 2, 32'd8);
        check("midwr_step_old", N*W'(ch(3)), N*W'(v + 32'd4));
        run(1);
        check("midwr_step_old2", N*W'(ch(3)), N*W'(v + 32'd8));
        cyc(1, 1, 1, 0, 4'd0, '0);
        check("init_in_dis", N*W'(ch(3)), '0);
        run(1);
        check("new_step", N*W'(ch(3)), N*W'(32'd8));

        cyc(1, 1, 0, 1, ad(0, 1), 32'h12345678);
        check("same_cyc_old_start", N*W'(ch(0)), N*W'(32'hDEADBEEF));
        cyc(1, 1, 0, 0, 4'd0, '0);
        check("next_init_start", N*W'(ch(0)), N*W'(32'h12345678));

        wr(1, 0, 32'd2); wr(1, 1, 32'd7); wr(1, 2, 32'd0); wr(1, 3, 32'hFFFFFFFF);
        cyc(1, 1, 0, 0, 4'd0, '0);
        run(3);
        check("step0_ch1", N*W'(ch(1)), N*W'(32'd7));

`ifdef CONST_SEQ_GEN_LIMIT_EN
        wr(3, 1, 32'd2); wr(3, 2, 32'd3); wr(3, 3, 32'd10);
        cyc(1, 1, 0, 0, 4'd0, '0);
        check("lim_start", N*W'(ch(3)), N*W'(32'd2));
        run(2);
        check("lim_8", N*W'(ch(3)), N*W'(32'd8));
        run(1);
        check("lim_reload", N*W'(ch(3)), N*W'(32'd2));
        check("lim_wrap", N*W'(wrap[3]), N*W'(1));
`else
        wr(3, 3, 32'd1);
        cyc(1, 1, 0, 0, 4'd0, '0);
        run(3);
        check("no_limit_ch3", N*W'(ch(3)), N*W'(32'd24));
`endif

        cyc(0, 0, 0, 0, 4'd0, '0);
        check("midrst_out", dout, '0);
        check("midrst_valid", N*W'(valid), '0);
        wr(2, 0, 32'd2); wr(2, 2, 32'd1);
        run(3);
        check("no_adv_pre_init", dout, '0);

        for (int k = 0; k < 400; k++) begin
            cyc($urandom_range(0, 59) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
                ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 20)) - 32'd8);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/const_seq_gen.md
Name: const_seq_gen

Overview:
Parametrised multi-channel constant/sequence source. Successor to the fixed zero-constant generator in the dataflow library.
- Each of NCH channels is runtime-configurable: zero, constant or ramp (accumulating step).
- Outputs are registered. A per-channel wrap pulse is provided.
- Sits at dataflow graph inputs as a programmable stimulus/offset/address source.

Parameters:
- WIDTH, 32, data width of each channel output and config value.
- NCH, 4, number of independent channels (1..16).
- ADDR_W, $clog2(NCH)+2, config address width: {channel index, 2-bit field}.

Ports:
- const_seq_gen_clk  in  1  single clock; all logic on rising edge.
- const_seq_gen_reset  in  1  synchronous reset, active-low.
- const_seq_gen_init  in  1  synchronous re-start pulse, active-high.
- const_seq_gen_in_disable  in  1  freeze all channels, active-high.
- const_seq_gen_cfg_we  in  1  config write strobe.
- const_seq_gen_cfg_addr  in  ADDR_W  [ADDR_W-1:2] = channel; [1:0] = field (0 mode, 1 start, 2 step, 3 limit).
- const_seq_gen_cfg_wdata  in  WIDTH  config data; mode uses bits [1:0].
- const_seq_gen_out  out  NCH*WIDTH  channel c at bits [c*WIDTH +: WIDTH].
- const_seq_gen_out_valid  out  1  high once the first init after reset has completed.
- const_seq_gen_wrap  out  NCH  one-cycle pulse per channel on ramp wrap.

Behaviour:
- Reset (reset==0 at clk edge): all mode/start/step/limit = 0; out = 0; out_valid = 0; wrap = 0. Reset dominates everything.
- Modes: 0 ZERO (out forced 0), 1 CONST (out = start), 2 RAMP, 3 reserved (behaves as ZERO).
- Config write: registers the field in the addressed channel at the clk edge. A channel index >= NCH is ignored.
  - New config reaches outputs only at the next init, never mid-sequence.
- Init, cycle N: every channel loads out = start (0 for ZERO/reserved); wrap = 0. out_valid = 1 from cycle N+1; it stays 1 until reset.
  - Init takes precedence over disable.
  - Init in the same cycle as cfg_we uses the pre-write config values.
- Advance: each cycle with init=0, disable=0 and out_valid=1, a RAMP channel does out <= (out + step) mod 2^WIDTH.
  - wrap[c] = carry-out of that add, registered with out (same cycle as the wrapped value).
  - ZERO and CONST channels hold.
- Disable=1: all out hold; wrap = 0. No state advances.
- Before the first init, out stays 0 and no ramp advances.
- Latency: init to loaded output is 1 clock. Each ramp step is 1 clock; there is no combinational path from inputs to outputs.
- step = 0 in RAMP: out constant, no wrap.

Optional Feature:
CONST_SEQ_GEN_LIMIT_EN
- Defined: the limit field is implemented. A RAMP channel compares (out + step), computed WIDTH+1 bits unsigned, against limit.
  - If greater: out reloads start and wrap[c] pulses.
  - Otherwise out takes the sum; natural carry is then impossible.
- Undefined: the limit register is not built and writes to field 3 are ignored. Wrap is the natural 2^WIDTH carry only.

Decomposition:
- Package const_seq_gen_pkg holds:
  - mode encoding localparams (MODE_ZERO=2'd0, MODE_CONST=2'd1, MODE_RAMP=2'd2);
  - field encodings (FLD_MODE=0, FLD_START=1, FLD_STEP=2, FLD_LIMIT=3);
  - typedef of the per-channel config struct.
- One sub-module const_seq_gen_ch: the single-channel config registers, out register, adder/compare and wrap. It is instantiated NCH times by a generate loop.
- The top level holds address decode, the out_valid flag and output concatenation.

Test Plan:
- Reset low 2 cycles then high -> out=0, out_valid=0, wrap=0; cfg writes before init leave out=0.
- ch0 CONST start=0xDEADBEEF, ch1 ZERO; init -> next cycle out[ch0]=0xDEADBEEF, out[ch1]=0, out_valid=1; both hold over 10 cycles.
- ch2 RAMP start=0xFFFFFFFD step=1; init then run -> FFFFFFFD, FFFFFFFE, FFFFFFFF, 00000000 with wrap[2]=1 only on the 00000000 cycle.
- RAMP start=0 step=4, disable high cycles 3-5 -> out 0,4,8 held through disable, then 12; init during disable -> reloads 0.
- cfg_we changes step to 8 mid-ramp -> step stays 4 until next init, then 8. Same-cycle init+write uses old start.
- With CONST_SEQ_GEN_LIMIT_EN: start=2 step=3 limit=10 -> 2,5,8,2 with wrap pulse on reload; reset low mid-ramp -> out=0 next cycle, out_valid=0.
